mips32_run_ctrl: RTL and testbench
==================================

# mips32_run_ctrl

Program-load and run sequencer for the two-stage-clocked MIPS32 pipeline core. It accepts a program as a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory from address 0. On `start` it holds the core in reset for a fixed number of cycles, then enables it until the core reports halt or a cycle budget expires. It replaces hand-poking of memory, PC and halt state, giving a single controlled boot/run/finish sequence.

## Interface
Parameters:
- `ADDR_W`, 10: instruction-memory word-address width; capacity 2^ADDR_W words.
- `CNT_W`, 16: run-cycle counter width.
- `MAX_CYCLES`, 1024: run budget in cycles; must be ≥1 and <2^CNT_W.
- `CLEAR_CYCLES`, 2: cycles `core_rst_n` is held low before run; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `load_valid` in 1: load word present.
- `load_data` in 32: instruction word.
- `load_last` in 1: final word of the program.
- `load_ready` out 1: controller accepts a word.
- `start` in 1: launch execution of the loaded program.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 32: write data.
- `core_rst_n` out 1: core reset, active-low.
- `core_run` out 1: core clock-enable/run.
- `core_halted` in 1: core executed HLT.
- `busy` out 1: state is CLEAR or RUN.
- `done` out 1: run finished.
- `timeout` out 1: run ended on budget, not on halt.
- `cycle_count` out CNT_W: RUN cycles in the current/last run.
- `prog_len` out ADDR_W+1: words in the loaded program.

## Operation
States: IDLE, LOAD, READY, CLEAR, RUN, DONE. A beat is accepted when `load_valid && load_ready`.
- `load_ready` is decoded from the state register: 1 in IDLE, LOAD and DONE; 0 otherwise.
- IDLE/DONE, beat accepted: write the word at address 0, set `wr_ptr`=1, clear `done`/`timeout`. If `load_last` → READY with `prog_len`=1, else → LOAD.
- LOAD, beat accepted: write at `wr_ptr`, increment. If `load_last`, or the write targets address 2^ADDR_W−1 → READY with `prog_len`=`wr_ptr`+1. Beats beyond capacity are never accepted.
- READY: `start` → CLEAR. `start` is ignored in IDLE, LOAD, CLEAR and RUN.
- CLEAR: `core_rst_n`=0 for exactly CLEAR_CYCLES cycles, `cycle_count` cleared, then → RUN.
- RUN: `core_rst_n`=1, `core_run`=1, `cycle_count` increments every cycle.
  - Sampled `core_halted`=1 → DONE with `timeout`=0.
  - Otherwise, when `cycle_count` reaches MAX_CYCLES → DONE with `timeout`=1.
  - Halt and budget expiry in the same cycle: halt wins, `timeout`=0.
- DONE: `done`=1, `core_run`=0, `core_rst_n`=1 so core state stays inspectable; `cycle_count`, `timeout` and `prog_len` hold.
  - `start` → CLEAR, re-running the same program and clearing `done`.
  - An accepted beat begins a new load as in IDLE.
  - If `start` and a beat occur together, the beat wins.

## Timing
- Reset (async assert, synchronous release): state IDLE, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst_n`=0, `core_run`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0, `prog_len`=0; `load_ready`=1.
- All outputs except `load_ready` are registered.
- A beat accepted at edge N drives `imem_we`/`imem_addr`/`imem_wdata` for one cycle after N; memory writes at edge N+1. Back-to-back beats give a one-write-per-cycle stream.
- `start` sampled at edge N in READY: `core_rst_n` is low for the cycles after edges N..N+CLEAR_CYCLES−1, and `core_run` rises after edge N+CLEAR_CYCLES.
- `done` rises the cycle after the edge that samples `core_halted`; `core_run` falls at the same edge.
- `rst_n` asserted mid-LOAD or mid-RUN aborts immediately to reset values; the program must be reloaded.

## Test plan
- Load 9 words (`load_last` on the 9th), no gaps → `imem` writes addresses 0..8 with matching data on consecutive cycles, `prog_len`=9, state READY, `load_ready`=0.
- Load 4 words with `load_valid` gaps of 0–3 cycles, then `start`; `core_halted` raised after 37 RUN cycles → `core_rst_n` low exactly 2 cycles, `done`=1, `timeout`=0, `cycle_count`=37.
- MAX_CYCLES=16, `core_halted` never asserted → DONE after 16 RUN cycles, `timeout`=1, `cycle_count`=16; a further `start` re-runs and clears `done`.
- ADDR_W=3, 10 beats offered, no `load_last` → 8 accepted (addresses 0..7), `prog_len`=8, `load_ready`=0 from the 9th beat onward.
- `core_halted` asserted on the same cycle `cycle_count` hits MAX_CYCLES → `timeout`=0; `start` pulsed during LOAD and RUN → no effect.
- `rst_n` dropped mid-RUN → `core_rst_n`=0, `core_run`=0, `prog_len`=0, `load_ready`=1 asynchronously.

Source files
------------

// File: rtl/mips32_run_ctrl.sv
// mips32_run_ctrl: program-load and run sequencer for the MIPS32 pipeline core.
// Streams a program into instruction memory from address 0, then on start holds
// the core in reset for CLEAR_CYCLES cycles and runs it until halt or budget.
module mips32_run_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              core_run,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   prog_len
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_core_rst_n;
  logic              r_core_run;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [ADDR_W:0]   r_prog_len;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [CLR_W-1:0]  r_clr_cnt;

  logic              w_load_ready;
  logic              w_beat;
  logic              w_ptr_last;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_budget;
  logic              w_clr_end;

  logic              w_imem_we_nxt;
  logic [ADDR_W-1:0] w_imem_addr_nxt;
  logic [31:0]       w_imem_wdata_nxt;
  logic              w_timeout_nxt;
  logic [CNT_W-1:0]  w_cycle_count_nxt;
  logic [ADDR_W:0]   w_prog_len_nxt;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [CLR_W-1:0]  w_clr_cnt_nxt;

  assign w_load_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);
  assign w_beat       = load_valid && w_load_ready;
  assign w_ptr_last   = (r_wr_ptr == '1);
  assign w_cnt_inc    = r_cycle_count + 1'b1;
  assign w_budget     = (w_cnt_inc == CNT_W'(MAX_CYCLES));
  assign w_clr_end    = (r_clr_cnt == CLR_W'(CLEAR_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; in DONE an accepted beat takes priority over start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_beat) w_state_nxt = load_last ? S_READY : S_LOAD;
      S_LOAD:  if (w_beat && (load_last || w_ptr_last)) w_state_nxt = S_READY;
      S_READY: if (start) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_end) w_state_nxt = S_RUN;
      S_RUN:   if (core_halted || w_budget) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_beat)     w_state_nxt = load_last ? S_READY : S_LOAD;
        else if (start) w_state_nxt = S_CLEAR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered datapath and status outputs.
  always_comb begin
    w_imem_we_nxt     = 1'b0;
    w_imem_addr_nxt   = r_imem_addr;
    w_imem_wdata_nxt  = r_imem_wdata;
    w_timeout_nxt     = r_timeout;
    w_cycle_count_nxt = r_cycle_count;
    w_prog_len_nxt    = r_prog_len;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_clr_cnt_nxt     = '0;

    if (w_beat) begin
      w_imem_we_nxt    = 1'b1;
      w_imem_wdata_nxt = load_data;
      if (r_state == S_LOAD) begin
        w_imem_addr_nxt = r_wr_ptr;
        w_wr_ptr_nxt    = r_wr_ptr + 1'b1;
        if (load_last || w_ptr_last) begin
          w_prog_len_nxt = {1'b0, r_wr_ptr} + (ADDR_W + 1)'(1);
        end
      end else begin
        w_imem_addr_nxt = '0;
        w_wr_ptr_nxt    = ADDR_W'(1);
        w_timeout_nxt   = 1'b0;
        if (load_last) begin
          w_prog_len_nxt = (ADDR_W + 1)'(1);
        end
      end
    end

    if (r_state == S_CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + 1'b1;
    end

    if (r_state == S_RUN) begin
      w_cycle_count_nxt = w_cnt_inc;
      if (!core_halted && w_budget) begin
        w_timeout_nxt = 1'b1;
      end
    end

    if (w_state_nxt == S_CLEAR) begin
      w_cycle_count_nxt = '0;
      w_timeout_nxt     = 1'b0;
    end
  end

  // Output and datapath registers; run/reset/status flags follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imem_we     <= 1'b0;
      r_imem_addr   <= '0;
      r_imem_wdata  <= '0;
      r_core_rst_n  <= 1'b0;
      r_core_run    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_prog_len    <= '0;
      r_wr_ptr      <= '0;
      r_clr_cnt     <= '0;
    end else begin
      r_imem_we     <= w_imem_we_nxt;
      r_imem_addr   <= w_imem_addr_nxt;
      r_imem_wdata  <= w_imem_wdata_nxt;
      r_core_rst_n  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
      r_core_run    <= (w_state_nxt == S_RUN);
      r_busy        <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_RUN);
      r_done        <= (w_state_nxt == S_DONE);
      r_timeout     <= w_timeout_nxt;
      r_cycle_count <= w_cycle_count_nxt;
      r_prog_len    <= w_prog_len_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_clr_cnt     <= w_clr_cnt_nxt;
    end
  end

  assign load_ready  = w_load_ready;
  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign core_rst_n  = r_core_rst_n;
  assign core_run    = r_core_run;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;
  assign prog_len    = r_prog_len;

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Testbench for mips32_run_ctrl: memory writes are checked by a scoreboard
// monitor; run/status behaviour is checked with directed sequences.
module tb_mips32_run_ctrl;

  localparam int AW   = 4;
  localparam int CW   = 16;
  localparam int MAXC = 40;
  localparam int CLRC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [31:0]   load_data = '0;
  logic          load_last = 1'b0;
  logic          start = 1'b0;
  logic          core_halted = 1'b0;
  logic          load_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          core_run;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [AW:0]   prog_len;

  int vectors = 0;
  int miscompares = 0;
  logic [AW+31:0] exp_q[$];

  mips32_run_ctrl #(
    .ADDR_W(AW),
    .CNT_W(CW),
    .MAX_CYCLES(MAXC),
    .CLEAR_CYCLES(CLRC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .start(start),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .core_run(core_run),
    .core_halted(core_halted),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycle_count(cycle_count),
    .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every memory write must match the next queued entry.
  initial begin
    logic [AW+31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && imem_we) begin
        if (exp_q.size() == 0) begin
          chk("imem_unexpected_write", 64'(imem_we), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("imem_write", 64'({imem_addr, imem_wdata}), 64'(e));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input int addr);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    while (!load_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!load_ready) begin
      chk("load_ready_wait", 64'(load_ready), 64'd1);
    end else begin
      exp_q.push_back({AW'(addr), d});
      step(1);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Start from READY/DONE, run n RUN edges, optionally halting on the last one.
  task automatic run_prog(input int n, input logic halt, input logic exp_to);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("clr1_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("clr1_busy", 64'(busy), 64'd1);
    chk("clr1_done", 64'(done), 64'd0);
    step(1);
    chk("clr2_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("clr2_core_run", 64'(core_run), 64'd0);
    step(1);
    chk("run_core_rst_n", 64'(core_rst_n), 64'd1);
    chk("run_core_run", 64'(core_run), 64'd1);
    chk("run_count0", 64'(cycle_count), 64'd0);
    for (int i = 1; i < n; i++) begin
      start = (i == 5);
      step(1);
    end
    start = 1'b0;
    chk("pre_end_count", 64'(cycle_count), 64'(n - 1));
    chk("pre_end_done", 64'(done), 64'd0);
    chk("pre_end_core_run", 64'(core_run), 64'd1);
    core_halted = halt;
    step(1);
    core_halted = 1'b0;
    chk("end_done", 64'(done), 64'd1);
    chk("end_timeout", 64'(timeout), 64'(exp_to));
    chk("end_count", 64'(cycle_count), 64'(n));
    chk("end_core_run", 64'(core_run), 64'd0);
    chk("end_core_rst_n", 64'(core_rst_n), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_load_ready", 64'(load_ready), 64'd1);
  endtask

  logic [31:0] prog9 [9] = '{32'h2001000A, 32'h20020014, 32'h00221820, 32'hAC030000,
                             32'h8C040000, 32'h00832022, 32'h10800001, 32'h20050001,
                             32'hFC000000};
  logic [31:0] prog4 [4] = '{32'h24080005, 32'h25080001, 32'h1500FFFE, 32'hFC000000};
  int gaps [4] = '{0, 1, 3, 2};

  initial begin
    // Reset values
    step(1);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_core_run", 64'(core_run), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    chk("rst_prog_len", 64'(prog_len), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    rst_n = 1'b1;
    step(2);

    // 9-word back-to-back load
    for (int i = 0; i < 9; i++) send_beat(prog9[i], (i == 8), i);
    chk("load9_ready", 64'(load_ready), 64'd0);
    chk("load9_prog_len", 64'(prog_len), 64'd9);
    chk("load9_busy", 64'(busy), 64'd0);
    step(2);

    // Halt on the 37th RUN cycle, start pulse during RUN ignored
    run_prog(37, 1'b1, 1'b0);

    // Re-run from DONE with no halt: budget expiry
    run_prog(MAXC, 1'b0, 1'b1);

    // 4-word load with gaps; first beat collides with start (beat wins)
    for (int i = 0; i < 4; i++) begin
      if (i == 0) start = 1'b1;
      send_beat(prog4[i], (i == 3), i);
      start = 1'b0;
      if (i == 0) begin
        chk("beatwin_busy", 64'(busy), 64'd0);
        chk("beatwin_done", 64'(done), 64'd0);
        chk("beatwin_timeout", 64'(timeout), 64'd0);
        chk("beatwin_load_ready", 64'(load_ready), 64'd1);
      end
      if (i < 3) begin
        for (int g = 0; g < gaps[i]; g++) begin
          start = (g == 1);
          step(1);
        end
        start = 1'b0;
      end
    end
    chk("load4_startignored_busy", 64'(busy), 64'd0);
    chk("load4_prog_len", 64'(prog_len), 64'd4);
    chk("load4_ready", 64'(load_ready), 64'd0);

    // Halt coincides with budget expiry: halt wins
    run_prog(MAXC, 1'b1, 1'b0);

    // Capacity: 16 words accepted without load_last, further beats refused
    for (int i = 0; i < 16; i++) send_beat(32'hC0DE0000 + 32'(i * 3), 1'b0, i);
    chk("cap_prog_len", 64'(prog_len), 64'd16);
    chk("cap_ready", 64'(load_ready), 64'd0);
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("cap_refuse_ready", 64'(load_ready), 64'd0);
    end
    load_valid = 1'b0;
    step(2);

    // Short run, then a reset dropped mid-RUN
    run_prog(10, 1'b1, 1'b0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    chk("midrun_core_run", 64'(core_run), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("arst_core_run", 64'(core_run), 64'd0);
    chk("arst_prog_len", 64'(prog_len), 64'd0);
    chk("arst_load_ready", 64'(load_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cycle_count", 64'(cycle_count), 64'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
